dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-master arbiter for the single data-memory port behind the Bridge's DM side.
- Master 0 is the CPU data port (M stage). Master 1 is a secondary requester such as a DMA or debug loader.
- Grants one access per cycle and applies burst-limited round-robin when both masters request.
- Stalls the CPU while master 1 holds the port, and routes the 1-cycle-latency read data back to the master that issued the read.

Parameters:
- MAX_BURST, 4: max consecutive grants to one master while the other is waiting; legal range 1..15.
- CNT_W, 16: width of the saturating conflict counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; state is cleared while low.
- m0_req  in  1  CPU access request, held until accepted.
- m0_addr  in  32  CPU byte address.
- m0_wdata  in  32  CPU write data.
- m0_byteen  in  4  CPU byte enables; 0 means read.
- m0_stall  out  1  asserted when m0_req=1 and m0 is not granted this cycle.
- m0_rvalid  out  1  m0 read data valid on dm_rdata this cycle.
- m1_req  in  1  master-1 request, held until m1_gnt.
- m1_addr  in  32  master-1 byte address.
- m1_wdata  in  32  master-1 write data.
- m1_byteen  in  4  master-1 byte enables; 0 means read.
- m1_gnt  out  1  master-1 access accepted this cycle.
- m1_rvalid  out  1  m1 read data valid this cycle.
- rdata  out  32  dm_rdata passed through; qualified by m0_rvalid/m1_rvalid.
- dm_addr  out  32  DM address.
- dm_wdata  out  32  DM write data.
- dm_byteen  out  4  DM byte enables.
- dm_rdata  in  32  DM read data, valid 1 cycle after the address.
- conflict_cnt  out  CNT_W  cycles with both req=1, saturating.

Behaviour:
- State registers: last (1b), burst (4b), rd_pend (1b), rd_own (1b), conflict_cnt.
- Reset values (reset=0, asynchronous): last=1, burst=MAX_BURST, rd_pend=0, rd_own=0, conflict_cnt=0.
  - Consequence: m0_rvalid=m1_rvalid=0 during and immediately after reset.
  - Consequence: the first tie after reset is granted to m0.
- Grant selection, combinational each cycle:
  - Neither req: no grant.
  - Exactly one req: grant that master.
  - Both req: grant `last` if burst<MAX_BURST, otherwise grant the other master.
- DM drive:
  - Granted master's addr/wdata/byteen go to dm_*.
  - With no grant: dm_addr=0, dm_wdata=0, dm_byteen=0.
- Handshakes:
  - m1_gnt = grant to m1.
  - m0_stall = m0_req & ~grant0; this is a combinational path from m0_req/m1_req.
  - An access completes in the cycle it is granted. The master must hold its request fields stable until that cycle.
- Burst update on posedge, only when a grant occurs:
  - If granted==last: burst <= min(burst+1, MAX_BURST).
  - Otherwise: last <= granted, burst <= 1.
  - No grant: last and burst hold.
- Read return:
  - rd_pend <= (grant & granted byteen==0); rd_own <= granted master.
  - Next cycle: m0_rvalid = rd_pend & rd_own==0; m1_rvalid = rd_pend & rd_own==1.
  - rdata = dm_rdata every cycle.
  - Back-to-back reads from alternating masters each get their own rvalid in consecutive cycles.
- Writes (byteen≠0) produce no rvalid.
- conflict_cnt increments when m0_req&m1_req; it holds at all-ones.
- Fairness: a continuously waiting master is granted within MAX_BURST cycles.
- Reset mid-operation: a pending rvalid is dropped; no DM write is issued while reset=0 (dm_byteen=0 in that state).

Test Plan:
- Reset release, m0 read addr 0x100, m1 idle:
  - Cycle 0: dm_addr=0x100, dm_byteen=0, m0_stall=0.
  - Cycle 1: m0_rvalid=1 and rdata=dm_rdata.
- m0 and m1 both request continuously with MAX_BURST=4:
  - Grants go m0 ×4, then m1 ×4, then m0 ×4.
  - m0_stall=1 exactly in the m1 cycles.
  - conflict_cnt=12 after 12 cycles.
- m1 write byteen=4'b0011 addr 0x2004 wdata 0xDEADBEEF alone:
  - Same cycle: m1_gnt=1, dm_byteen=4'b0011.
  - No rvalid on either master the next cycle.
- Alternating reads m0@0x10, m1@0x20, m0@0x30 under contention:
  - rvalid sequence is m0, m1, m0 with the matching rd_own each cycle.
- reset driven low for 1 cycle while a read is pending:
  - rd_pend clears immediately; no rvalid.
  - After release, last=1 and burst=MAX_BURST, so the next tie grants m0.
- Hold m0_req&m1_req for 2^CNT_W+5 cycles:
  - conflict_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter for the single data-memory port.
// Master 0 is the CPU data port, master 1 a secondary requester (DMA/debug).
// One access is granted per cycle; under contention a master keeps the port
// for at most MAX_BURST consecutive grants before the other is served.
// Read data has one cycle of latency and is steered back to its issuer.
module dm_arbiter #(
  parameter int unsigned MAX_BURST = 4,   // legal range 1..15
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active-low

  input  logic             m0_req,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  input  logic [3:0]       m0_byteen,
  output logic             m0_stall,
  output logic             m0_rvalid,

  input  logic             m1_req,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic [3:0]       m1_byteen,
  output logic             m1_gnt,
  output logic             m1_rvalid,

  output logic [31:0]      rdata,

  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [3:0]       dm_byteen,
  input  logic [31:0]      dm_rdata,

  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  // Arbitration state: owner of the current run and its length so far.
  logic       last;
  logic [3:0] burst;
  // Read return tracking: a read was granted last cycle, and by whom.
  logic       rd_pend;
  logic       rd_own;

  logic       gnt0;
  logic       gnt1;
  logic       any_gnt;
  logic       sel;       // granted master index, meaningful only with any_gnt
  logic       conflict;

  assign conflict = m0_req & m1_req;

  // Grant selection; nothing is granted while reset is held low, so no DM
  // access can be issued in that state.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (conflict) begin
        if (burst < MAX_B) begin
          gnt0 = ~last;
          gnt1 = last;
        end else begin
          gnt0 = last;
          gnt1 = ~last;
        end
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  assign any_gnt = gnt0 | gnt1;
  assign sel     = gnt1;

  // Route the granted master onto the DM port; idle port drives zeros.
  always_comb begin
    dm_addr   = 32'h0;
    dm_wdata  = 32'h0;
    dm_byteen = 4'h0;
    if (gnt0) begin
      dm_addr   = m0_addr;
      dm_wdata  = m0_wdata;
      dm_byteen = m0_byteen;
    end else if (gnt1) begin
      dm_addr   = m1_addr;
      dm_wdata  = m1_wdata;
      dm_byteen = m1_byteen;
    end
  end

  assign m0_stall = m0_req & ~gnt0;
  assign m1_gnt   = gnt1;

  // Read data is forwarded unconditionally; the rvalids qualify it.
  assign rdata     = dm_rdata;
  assign m0_rvalid = rd_pend & ~rd_own;
  assign m1_rvalid = rd_pend &  rd_own;

  // Burst tracking, read-return bookkeeping and the saturating conflict count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // The first tie after reset goes to master 0: last=1 with a full burst
      // forces the "other master" choice.
      last         <= 1'b1;
      burst        <= MAX_B;
      rd_pend      <= 1'b0;
      rd_own       <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before this clock edge.
      if (any_gnt) begin
        if (sel == last) begin
          if (burst < MAX_B) begin
            burst <= burst + 4'd1;
          end
        end else begin
          last  <= sel;
          burst <= 4'd1;
        end
      end
      rd_pend <= any_gnt & (dm_byteen == 4'h0);
      rd_own  <= sel;
      if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scenario tasks drive dm_arbiter and check grants/DM drive
// inline; expected read returns go into a scoreboard queue that a monitor
// pops and compares when the rvalid cycle comes around.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic        m0_stall, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] rdata, dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_byteen;
  logic [15:0] conflict_cnt;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic        own;
    logic [31:0] data;
    int unsigned due;
  } rd_exp_t;

  rd_exp_t sb[$];

  dm_arbiter #(.MAX_BURST(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_byteen(m0_byteen), .m0_stall(m0_stall), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_byteen(m1_byteen), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_byteen(dm_byteen), .dm_rdata(dm_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory stand-in: read data is a fixed function of the address,
  // returned one cycle after the address is presented.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
  endfunction

  always @(posedge clk) dm_rdata <= mem_val(dm_addr);

  // Scoreboard monitor: each cycle either the expected read returns or
  // neither rvalid may be high.
  always @(negedge clk) begin
    rd_exp_t e;
    if (reset !== 1'b1) begin
      sb.delete();
      checks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rvalid_in_reset: m0_rvalid=%b m1_rvalid=%b, need 0/0", m0_rvalid, m1_rvalid);
      end
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checks++;
      if (m0_rvalid !== ~e.own || m1_rvalid !== e.own || rdata !== e.data) begin
        errors++;
        $display("FAIL read_return: m0_rvalid=%b m1_rvalid=%b rdata=%h, need %b/%b rdata=%h",
                 m0_rvalid, m1_rvalid, rdata, ~e.own, e.own, e.data);
      end
    end else begin
      checks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL spurious_rvalid: m0_rvalid=%b m1_rvalid=%b, need 0/0", m0_rvalid, m1_rvalid);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_byteen = 4'h0;
    m1_req = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_byteen = 4'h0;
  endtask

  task automatic expect_read(input logic own, input logic [31:0] addr);
    sb.push_back('{own, mem_val(addr), cyc + 1});
  endtask

  task automatic do_reset();
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h44; m0_byteen = 4'hF; m0_wdata = 32'h1111_1111;
    m1_req = 1'b1; m1_addr = 32'h88; m1_byteen = 4'hF; m1_wdata = 32'h2222_2222;
    settle();
    checks++;
    if (dm_byteen !== 4'h0) begin
      errors++; $display("FAIL reset_no_write: dm_byteen=%h, need 0", dm_byteen);
    end
    checks++;
    if (m1_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_no_gnt: m1_gnt=%b, need 0", m1_gnt);
    end
    next_cycle();
    idle_inputs();
    reset = 1'b1;
    settle();
    checks++;
    if (conflict_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: conflict_cnt=%h, need 0", conflict_cnt);
    end
    checks++;
    if (dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin
      errors++; $display("FAIL idle_dm: dm_addr=%h dm_wdata=%h, need 0/0", dm_addr, dm_wdata);
    end
  endtask

  task automatic test_single_read();
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h100; m0_byteen = 4'h0;
    settle();
    checks++;
    if (dm_addr !== 32'h100 || dm_byteen !== 4'h0 || m0_stall !== 1'b0 || m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL single_read: dm_addr=%h dm_byteen=%h m0_stall=%b m1_gnt=%b, need 100/0/0/0",
               dm_addr, dm_byteen, m0_stall, m1_gnt);
    end
    expect_read(1'b0, 32'h100);
    next_cycle();
    idle_inputs();
    settle();
    checks++;
    if (dm_addr !== 32'h0 || dm_byteen !== 4'h0) begin
      errors++; $display("FAIL single_idle: dm_addr=%h dm_byteen=%h, need 0/0", dm_addr, dm_byteen);
    end
  endtask

  task automatic test_contention();
    logic exp_m1;
    do_reset();
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h400; m0_byteen = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h800; m1_byteen = 4'h0;
    for (int i = 0; i < 12; i++) begin
      settle();
      exp_m1 = (i >= 4 && i < 8);
      checks++;
      if (m1_gnt !== exp_m1 || m0_stall !== exp_m1) begin
        errors++;
        $display("FAIL contention_gnt[%0d]: m1_gnt=%b m0_stall=%b, need %b/%b",
                 i, m1_gnt, m0_stall, exp_m1, exp_m1);
      end
      checks++;
      if (dm_addr !== (exp_m1 ? 32'h800 : 32'h400)) begin
        errors++;
        $display("FAIL contention_addr[%0d]: dm_addr=%h, need %h",
                 i, dm_addr, exp_m1 ? 32'h800 : 32'h400);
      end
      checks++;
      if (conflict_cnt !== 16'(i)) begin
        errors++; $display("FAIL contention_cnt[%0d]: conflict_cnt=%0d, need %0d", i, conflict_cnt, i);
      end
      expect_read(exp_m1, exp_m1 ? 32'h800 : 32'h400);
      next_cycle();
    end
    idle_inputs();
    settle();
    checks++;
    if (conflict_cnt !== 16'd12) begin
      errors++; $display("FAIL contention_cnt_final: conflict_cnt=%0d, need 12", conflict_cnt);
    end
  endtask

  task automatic test_m1_write();
    next_cycle();
    m1_req = 1'b1; m1_addr = 32'h2004; m1_wdata = 32'hDEAD_BEEF; m1_byteen = 4'b0011;
    settle();
    checks++;
    if (m1_gnt !== 1'b1 || dm_byteen !== 4'b0011 || dm_addr !== 32'h2004 ||
        dm_wdata !== 32'hDEAD_BEEF || m0_stall !== 1'b0) begin
      errors++;
      $display("FAIL m1_write: m1_gnt=%b dm_byteen=%b dm_addr=%h dm_wdata=%h m0_stall=%b, need 1/0011/2004/deadbeef/0",
               m1_gnt, dm_byteen, dm_addr, dm_wdata, m0_stall);
    end
    next_cycle();
    idle_inputs();
    settle();
    checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL write_no_rvalid: m0_rvalid=%b m1_rvalid=%b, need 0/0", m0_rvalid, m1_rvalid);
    end
  endtask

  task automatic test_alternating();
    do_reset();
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h10; m0_byteen = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h20; m1_byteen = 4'h0;
    settle();
    checks++;
    if (m1_gnt !== 1'b0 || m0_stall !== 1'b0 || dm_addr !== 32'h10) begin
      errors++;
      $display("FAIL alt_first: m1_gnt=%b m0_stall=%b dm_addr=%h, need 0/0/10", m1_gnt, m0_stall, dm_addr);
    end
    expect_read(1'b0, 32'h10);
    next_cycle();
    m0_req = 1'b0;
    settle();
    checks++;
    if (m1_gnt !== 1'b1 || dm_addr !== 32'h20) begin
      errors++; $display("FAIL alt_second: m1_gnt=%b dm_addr=%h, need 1/20", m1_gnt, dm_addr);
    end
    expect_read(1'b1, 32'h20);
    next_cycle();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h30;
    settle();
    checks++;
    if (m0_stall !== 1'b0 || dm_addr !== 32'h30) begin
      errors++; $display("FAIL alt_third: m0_stall=%b dm_addr=%h, need 0/30", m0_stall, dm_addr);
    end
    expect_read(1'b0, 32'h30);
    next_cycle();
    idle_inputs();
    settle();
  endtask

  task automatic test_reset_pending();
    next_cycle();
    m1_req = 1'b1; m1_addr = 32'h40; m1_byteen = 4'h0;
    settle();
    expect_read(1'b1, 32'h40);
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    settle();
    checks++;
    if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL pending_dropped: m0_rvalid=%b m1_rvalid=%b, need 0/0", m0_rvalid, m1_rvalid);
    end
    next_cycle();
    reset = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h50; m0_byteen = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h60; m1_byteen = 4'h0;
    settle();
    checks++;
    if (m1_gnt !== 1'b0 || m0_stall !== 1'b0 || dm_addr !== 32'h50) begin
      errors++;
      $display("FAIL tie_after_reset: m1_gnt=%b m0_stall=%b dm_addr=%h, need 0/0/50", m1_gnt, m0_stall, dm_addr);
    end
    expect_read(1'b0, 32'h50);
    next_cycle();
    idle_inputs();
    settle();
  endtask

  task automatic test_saturate();
    do_reset();
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h1000; m0_byteen = 4'hF; m0_wdata = 32'hA;
    m1_req = 1'b1; m1_addr = 32'h2000; m1_byteen = 4'hF; m1_wdata = 32'hB;
    for (int i = 0; i < 65541; i++) begin
      settle();
      if (i == 65534) begin
        checks++;
        if (conflict_cnt !== 16'hFFFE) begin
          errors++; $display("FAIL sat_pre: conflict_cnt=%h, need fffe", conflict_cnt);
        end
      end
      if (i == 65535) begin
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin
          errors++; $display("FAIL sat_reach: conflict_cnt=%h, need ffff", conflict_cnt);
        end
      end
      next_cycle();
    end
    idle_inputs();
    settle();
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: conflict_cnt=%h, need ffff", conflict_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;
    reset = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_m1_write();
    test_alternating();
    test_reset_pending();
    test_saturate();
    next_cycle();
    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
